// File: rtl/uart_rxtx.sv
// 8N1 UART receiver and transmitter sharing one clock and bit period.
// RX: po_flag 3+8*BAUD_END+BAUD_M cycles after the first sampled low; TX: line low one cycle after tx_trig.
// No backpressure: tx_trig is dropped while a frame is in flight, rx bytes must be taken on po_flag.
module uart_rxtx #(
    parameter int BAUD_END = 5208,
    parameter int BAUD_M   = BAUD_END / 2 - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag,
    input  logic       tx_trig,
    input  logic [7:0] tx_data,
    output logic       rs232_tx,
    output logic       tx_busy
);
    localparam int CW = (BAUD_END > 1) ? $clog2(BAUD_END) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_END - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(BAUD_M);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;

    logic          r1, r2, r3;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_sample;

    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic [2:0]    tx_idx;
    logic          tx_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    // A falling edge seen between r3 and r2 marks a start bit.
    always_comb begin
        rx_next   = rx_state;
        rx_sample = (rx_state == RX_RECV) && (rx_baud == SAMPLE_AT);
        case (rx_state)
            RX_IDLE: if (!r2 && r3) rx_next = RX_RECV;
            RX_RECV: if (rx_sample && ((rx_bit == 4'd0 && r3) || rx_bit == 4'd8))
                         rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1       <= 1'b1;
            r2       <= 1'b1;
            r3       <= 1'b1;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            po_flag  <= 1'b0;
        end else begin
            r1      <= rs232_rx;
            r2      <= r1;
            r3      <= r2;
            po_flag <= 1'b0;
            if (rx_state == RX_IDLE) begin
                rx_baud <= '0;
                rx_bit  <= '0;
            end else begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud <= '0;
                    rx_bit  <= rx_bit + 4'd1;
                end else begin
                    rx_baud <= rx_baud + CW'(1);
                end
                // Data arrives LSB first, so shifting right leaves bit 0 at the bottom.
                if (rx_sample && rx_bit != 4'd0) begin
                    rx_shift <= {r3, rx_shift[7:1]};
                    if (rx_bit == 4'd8) begin
                        rx_data <= {r3, rx_shift[7:1]};
                        po_flag <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_trig) tx_next = TX_SEND;
            TX_SEND: if (tx_bit == 4'd9 && tx_baud == BAUD_LAST) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_idx   = 3'(tx_bit - 4'd1);
        tx_level = 1'b1;
        if (tx_bit == 4'd0)
            tx_level = 1'b0;
        else if (tx_bit <= 4'd8)
            tx_level = tx_shift[tx_idx];
    end

    // Line and busy are registered from the current bit, so both lag the counters by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            rs232_tx <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            rs232_tx <= (tx_state == TX_SEND) ? tx_level : 1'b1;
            tx_busy  <= (tx_state == TX_SEND);
            if (tx_state == TX_IDLE) begin
                tx_baud <= '0;
                tx_bit  <= '0;
                if (tx_trig) tx_shift <= tx_data;
            end else if (tx_baud == BAUD_LAST) begin
                tx_baud <= '0;
                tx_bit  <= tx_bit + 4'd1;
            end else begin
                tx_baud <= tx_baud + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_rxtx.sv
// Scoreboard bench for uart_rxtx at BAUD_END=56: stimulus pushes expected bytes and
// arrival cycles, independent monitors pop and compare on po_flag and on each TX frame.
module tb_uart_rxtx;
    localparam int BAUD   = 56;
    localparam int RX_LAT = 478;  // first low sampled (F) to po_flag edge
    localparam int TX_LAT = 480;  // F to first low rs232_tx edge in loopback

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       trig_drv = 1'b0;
    logic [7:0] data_drv = 8'h00;
    logic       loop = 1'b0;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       rs232_tx;
    logic       tx_busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic tx_abort_ok = 1'b0;
    exp_t rxq[$];
    exp_t txq[$];

    assign tx_trig = loop ? po_flag : trig_drv;
    assign tx_data = loop ? rx_data : data_drv;

    uart_rxtx #(.BAUD_END(BAUD), .BAUD_M(27)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .rx_data  (rx_data),
        .po_flag  (po_flag),
        .tx_trig  (tx_trig),
        .tx_data  (tx_data),
        .rs232_tx (rs232_tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called just after a rising edge; the next edge is the one that captures the start bit.
    task automatic send_rx(input logic [7:0] b, input bit expect_it, input int stop_bits);
        logic [9:0] fr;
        exp_t e;
        fr = {1'b1, b, 1'b0};
        if (expect_it) begin
            e.data = b;
            e.at   = cyc + 1 + RX_LAT;
            rxq.push_back(e);
            if (loop) begin
                e.at = cyc + 1 + TX_LAT;
                txq.push_back(e);
            end
        end
        for (int i = 0; i < 9 + stop_bits; i++) begin
            rs232_rx = (i < 10) ? fr[i] : 1'b1;
            repeat (BAUD) @(posedge clk);
            #1;
        end
    endtask

    task automatic tx_pulse(input logic [7:0] d, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.data = d;
            e.at   = cyc + 2;
            txq.push_back(e);
        end
        data_drv = d;
        trig_drv = 1'b1;
        @(posedge clk);
        #1;
        trig_drv = 1'b0;
    endtask

    always @(negedge clk) begin : rx_mon
        exp_t e;
        if (po_flag === 1'b1) begin
            if (rxq.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: po_flag=1 data %0h at cycle %0d, expected no pulse", rx_data, cyc);
            end else begin
                e = rxq.pop_front();
                check("rx_data", rx_data, e.data);
                check("rx_time", cyc, e.at);
            end
        end
    end

    initial begin : tx_mon
        logic       prev;
        logic       ok;
        logic [9:0] fr;
        int         s;
        exp_t       e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && rs232_tx === 1'b0) begin
                s = cyc;
                if (txq.size() == 0) begin
                    if (!tx_abort_ok) begin
                        n_checks++;
                        $display("FAIL tx_unexpected: frame start at cycle %0d, expected idle line", s);
                    end
                    while (rs232_tx !== 1'b1) @(negedge clk);
                end else begin
                    e = txq.pop_front();
                    check("tx_start", s, e.at);
                    fr = {1'b1, e.data, 1'b0};
                    ok = 1'b1;
                    for (int i = 0; i < 10 * BAUD; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rs232_tx !== fr[i / BAUD] || tx_busy !== 1'b1) ok = 1'b0;
                    end
                    check("tx_frame", ok, 1);
                    @(negedge clk);
                    check("tx_end", {rs232_tx, tx_busy}, 2'b10);
                end
            end
            prev = rs232_tx;
        end
    end

    initial begin : main
        logic ok;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_po_flag", po_flag, 1'b0);
        check("rst_rs232_tx", rs232_tx, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rx_data !== 8'h00 || po_flag !== 1'b0 || rs232_tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
        end
        check("idle_hold", ok, 1);
        @(posedge clk);
        #1;

        // back-to-back frames
        send_rx(8'h55, 1, 1);
        send_rx(8'hA3, 1, 1);
        send_rx(8'h00, 1, 1);
        send_rx(8'hFF, 1, 1);
        repeat (100) @(posedge clk);
        #1;

        // loopback, two idle bit periods between frames
        loop = 1'b1;
        send_rx(8'h55, 1, 3);
        send_rx(8'hA3, 1, 3);
        send_rx(8'h00, 1, 3);
        send_rx(8'hFF, 1, 3);
        repeat (500) @(posedge clk);
        #1;
        loop = 1'b0;

        // 20-cycle glitch, then a real byte
        rs232_rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rs232_rx = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        send_rx(8'h3C, 1, 1);
        repeat (100) @(posedge clk);
        #1;

        // second trigger during SEND is ignored
        tx_pulse(8'h81, 1);
        repeat (99) @(posedge clk);
        #1;
        tx_pulse(8'h7E, 0);
        repeat (600) @(posedge clk);
        #1;

        // reset during bit 4 of an RX and a TX frame
        tx_abort_ok = 1'b1;
        fork
            send_rx(8'hC3, 0, 1);
            begin
                tx_pulse(8'h99, 0);
                repeat (4 * BAUD + 20) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("abort_rs232_tx", rs232_tx, 1'b1);
                check("abort_tx_busy", tx_busy, 1'b0);
                check("abort_rx_data", rx_data, 8'h00);
            end
        join
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        tx_abort_ok = 1'b0;
        check("after_abort_rx_data", rx_data, 8'h00);
        check("after_abort_tx_busy", tx_busy, 1'b0);

        // recovery after reset
        send_rx(8'h5A, 1, 1);
        repeat (50) @(posedge clk);
        #1;
        tx_pulse(8'hC6, 1);
        repeat (700) @(posedge clk);
        #1;

        check("rx_queue_empty", rxq.size(), 0);
        check("tx_queue_empty", txq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
